// File: rtl/sprite_motion_ctrl.sv
// sprite_motion_ctrl
//   Player-sprite controller for the VGA game pipeline. A sized sprite walks
//   horizontally (wrapping or clamping at the limits) and jumps under gravity
//   between a ceiling and a floor. Position, velocity and the vertical state
//   advance once per frame tick. Fill and colour for the current pixel are
//   combinational.
//
// Ports
//   clk            system clock
//   rst            asynchronous, active-high reset
//   tick           one-cycle frame enable; all state advances only when set
//   up/left/right  level button inputs, sampled on tick
//   hCount/vCount  current pixel counters
//   bg             colour used for non-sprite pixels
//   rgb            COLOR when fill, else bg
//   fill           current pixel lies inside the sprite box
//   xpos/ypos      sprite centre
//   state          0 GROUNDED, 1 RISING, 2 FALLING
//   facing         1 = right, 0 = left
module sprite_motion_ctrl #(
  parameter int HALF_W   = 5,
  parameter int HALF_H   = 5,
  parameter int STEP     = 2,
  parameter int JUMP_V   = 12,
  parameter int GRAVITY  = 1,
  parameter int MAX_FALL = 8,
  parameter int X_MIN    = 150,
  parameter int X_MAX    = 780,
  parameter int Y_MIN    = 40,
  parameter int Y_FLOOR  = 500,
  parameter int X_INIT   = 450,
  parameter int WRAP_X   = 1,
  parameter logic [11:0] COLOR = 12'hF00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        up,
  input  logic        left,
  input  logic        right,
  input  logic [9:0]  hCount,
  input  logic [9:0]  vCount,
  input  logic [11:0] bg,
  output logic [11:0] rgb,
  output logic        fill,
  output logic [9:0]  xpos,
  output logic [9:0]  ypos,
  output logic [1:0]  state,
  output logic        facing
);

  localparam logic [1:0] GROUNDED = 2'd0;
  localparam logic [1:0] RISING   = 2'd1;
  localparam logic [1:0] FALLING  = 2'd2;

  // 11-bit signed copies so sums and differences of positions never wrap
  localparam logic signed [10:0] STEP_S   = 11'(STEP);
  localparam logic signed [10:0] HW_S     = 11'(HALF_W);
  localparam logic signed [10:0] HH_S     = 11'(HALF_H);
  localparam logic signed [10:0] XMIN_S   = 11'(X_MIN);
  localparam logic signed [10:0] XMAX_S   = 11'(X_MAX);
  localparam logic signed [10:0] YMIN_S   = 11'(Y_MIN);
  localparam logic signed [10:0] YFLOOR_S = 11'(Y_FLOOR);

  localparam logic [9:0] XMIN_U   = 10'(X_MIN);
  localparam logic [9:0] XMAX_U   = 10'(X_MAX);
  localparam logic [9:0] YMIN_U   = 10'(Y_MIN);
  localparam logic [9:0] YFLOOR_U = 10'(Y_FLOOR);
  localparam logic [9:0] XINIT_U  = 10'(X_INIT);

  localparam logic signed [7:0] JUMP_S = 8'(JUMP_V);
  localparam logic signed [7:0] GRAV_S = 8'(GRAVITY);
  localparam logic signed [7:0] MAXF_S = 8'(MAX_FALL);

  logic signed [7:0]  vy;
  logic signed [7:0]  vy_nxt;
  logic signed [7:0]  vy_inc;
  logic signed [10:0] xs;
  logic signed [10:0] ys;
  logic signed [10:0] hs;
  logic signed [10:0] vs;
  logic signed [10:0] vy_ext;
  logic signed [10:0] ysum;
  logic [9:0]         x_nxt;
  logic [9:0]         y_nxt;
  logic [1:0]         st_nxt;
  logic               face_nxt;

  assign xs     = {1'b0, xpos};
  assign ys     = {1'b0, ypos};
  assign hs     = {1'b0, hCount};
  assign vs     = {1'b0, vCount};
  assign vy_ext = {{3{vy[7]}}, vy};
  assign ysum   = ys + vy_ext;
  assign vy_inc = vy + GRAV_S;

  always_comb begin
    x_nxt    = xpos;
    face_nxt = facing;
    if (right && !left) begin
      face_nxt = 1'b1;
      if (xs + STEP_S > XMAX_S)
        x_nxt = (WRAP_X != 0) ? XMIN_U : XMAX_U;
      else
        x_nxt = 10'(xs + STEP_S);
    end else if (left && !right) begin
      face_nxt = 1'b0;
      if (xs < XMIN_S + STEP_S)
        x_nxt = (WRAP_X != 0) ? XMAX_U : XMIN_U;
      else
        x_nxt = 10'(xs - STEP_S);
    end
  end

  always_comb begin
    y_nxt  = ypos;
    vy_nxt = vy;
    st_nxt = state;
    case (state)
      GROUNDED: begin
        if (up) begin
          vy_nxt = -JUMP_S;
          st_nxt = RISING;
        end
      end
      RISING: begin
        if (ysum <= YMIN_S) begin
          y_nxt  = YMIN_U;
          vy_nxt = '0;
          st_nxt = FALLING;
        end else begin
          y_nxt  = 10'(ysum);
          vy_nxt = vy_inc;
          // apex reached once the updated velocity is no longer upward
          if (!vy_inc[7]) st_nxt = FALLING;
        end
      end
      FALLING: begin
        if (ysum >= YFLOOR_S) begin
          y_nxt  = YFLOOR_U;
          vy_nxt = '0;
          st_nxt = GROUNDED;
        end else begin
          y_nxt  = 10'(ysum);
          vy_nxt = (vy_inc > MAXF_S) ? MAXF_S : vy_inc;
        end
      end
      default: st_nxt = FALLING;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xpos   <= XINIT_U;
      ypos   <= YFLOOR_U;
      vy     <= '0;
      state  <= GROUNDED;
      facing <= 1'b1;
    end else if (tick) begin
      xpos   <= x_nxt;
      ypos   <= y_nxt;
      vy     <= vy_nxt;
      state  <= st_nxt;
      facing <= face_nxt;
    end
  end

  // signed box test: an edge above row 0 or left of column 0 clips
  assign fill = (hs >= xs - HW_S) && (hs <= xs + HW_S) &&
                (vs >= ys - HH_S) && (vs <= ys + HH_S);
  assign rgb  = fill ? COLOR : bg;

endmodule

// File: doc/sprite_motion_ctrl.md
# sprite_motion_ctrl

Parametrised player-sprite controller for the VGA game pipeline. It replaces the fixed 10x10 free-moving block with a sized sprite that has horizontal walking (wrap or clamp mode), gravity-driven jumping with a ceiling and floor, and a facing flag. It sits between the debounced button inputs and the display controller's pixel mux. It updates once per frame tick and produces combinational sprite fill and colour for the current (hCount, vCount).

## Interface
- HALF_W, 5: sprite half-width in pixels; sprite spans xpos±HALF_W.
- HALF_H, 5: sprite half-height; sprite spans ypos±HALF_H.
- STEP, 2: horizontal pixels moved per tick.
- JUMP_V, 12: launch speed; vy set to −JUMP_V.
- GRAVITY, 1: vy increment per airborne tick.
- MAX_FALL, 8: vy saturation, downward.
- X_MIN, 150 / X_MAX, 780: horizontal centre limits.
- Y_MIN, 40 / Y_FLOOR, 500: ceiling and floor centre limits.
- X_INIT, 450: reset xpos. Reset ypos is Y_FLOOR.
- WRAP_X, 1: 1 = wrap at horizontal limits, 0 = clamp.
- COLOR, 12'hF00: sprite rgb.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- tick  in  1  one-cycle frame-rate enable; all state advances only on clk edges with tick=1.
- up, left, right  in  1 each  level button inputs, sampled on tick.
- hCount, vCount  in  10 each  current pixel counters.
- bg  in  12  background colour for non-sprite pixels.
- rgb  out  12  COLOR when fill, else bg (combinational).
- fill  out  1  current pixel inside sprite (combinational).
- xpos, ypos  out  10 each  sprite centre (registered).
- state  out  2  0 GROUNDED, 1 RISING, 2 FALLING (registered).
- facing  out  1  1 = right, 0 = left (registered).

## Operation
- Reset: xpos=X_INIT, ypos=Y_FLOOR, vy=0 (8-bit signed, internal), state=GROUNDED, facing=1. Reset during any state aborts the motion immediately.
- Horizontal, evaluated each tick in every state:
  - right&&!left: facing←1. If xpos+STEP > X_MAX, xpos←X_MIN (wrap) or X_MAX (clamp). Otherwise xpos+=STEP.
  - left&&!right: facing←0. If xpos < X_MIN+STEP, xpos←X_MAX (wrap) or X_MIN (clamp). Otherwise xpos−=STEP.
  - Both or neither pressed: xpos and facing hold.
- Vertical FSM, evaluated each tick:
  - GROUNDED: if up, vy←−JUMP_V and state←RISING; ypos does not change on the launch tick. Otherwise hold.
  - RISING: if ypos+vy ≤ Y_MIN, ypos←Y_MIN, vy←0, state←FALLING. Otherwise ypos+=vy and vy+=GRAVITY; if the new vy ≥ 0, state←FALLING.
  - FALLING: if ypos+vy ≥ Y_FLOOR, ypos←Y_FLOOR, vy←0, state←GROUNDED. Otherwise ypos+=vy and vy←min(vy+GRAVITY, MAX_FALL).
  - up is ignored while airborne. On the landing tick up is not acted on; if up is still held on the next tick, a new jump launches.
  - Value 3 of state is illegal and recovers to FALLING on the next tick.
- Arithmetic: all position sums and compares use 11-bit signed values so that ypos+vy, xpos−STEP and ypos−HALF_H never wrap.
- fill = hCount ∈ [xpos−HALF_W, xpos+HALF_W] and vCount ∈ [ypos−HALF_H, ypos+HALF_H], inclusive, evaluated signed. A sprite edge below 0 is therefore clipped, not wrapped.

## Timing
- Registered outputs change one clk edge after a tick-qualified sample. Horizontal and vertical updates land on the same edge.
- fill and rgb have zero latency from hCount, vCount and the registered positions.
- With tick=0, every register holds regardless of the button inputs.
- Defaults give a jump of 1 launch tick + 12 rising ticks + 15 falling ticks, with a peak ypos of 422.

## Test plan
- Reset then release, no buttons: xpos=450, ypos=500, state=0, facing=1. Pixel (445,495) gives fill=1, rgb=12'hF00. Pixel (444,500) gives fill=0, rgb=bg.
- Hold right with xpos=780 on a tick, WRAP_X=1: xpos=150, facing=1. Repeat with WRAP_X=0: xpos=780. Hold left+right: xpos and facing unchanged.
- Pulse up for one tick from the floor, defaults: state=RISING after tick 1; after tick 13, ypos=422 and state=FALLING; after tick 28, ypos=500 and state=GROUNDED. No position change while tick=0.
- Y_FLOOR=100, Y_MIN=60, up pressed: ypos goes 100, 100, 88, 77, 67, then 60 (clamped); state=FALLING with vy=0 on the clamp tick.
- Hold right and up together through a full jump: xpos increases by 2 every tick while airborne. The landing tick ignores up, and the next tick relaunches.
- Assert rst asynchronously mid-rise, between clk edges: outputs return to reset values immediately, without waiting for a clk edge.
